// File: rtl/uarttop.sv
// uarttop: 8N1 UART transmitter and receiver, each stepped by its own divided bit clock

// uart_div: divides clk down to the bit clock, toggling every clkcount/2 cycles
module uart_div #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic clk,
    input  logic rst,
    output logic u_clk
);
    localparam int clkcount = clk_freq / baud_rate;
    localparam int half     = clkcount / 2;
    localparam int cw       = $clog2(half + 1);

    logic [cw-1:0] count;

    // free-running half-period counter; the bit clock flips each time it wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            u_clk <= 1'b0;
        end else if (count == cw'(half - 1)) begin
            count <= '0;
            u_clk <= ~u_clk;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// uarttx: shifts out start bit, 8 data bits LSB first, then stop with a done pulse
module uarttx #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic [7:0] dintx,
    output logic       tx,
    output logic       donetx
);
    typedef enum logic {IDLE, TRANSFER} state_t;

    state_t     state, state_n;
    logic [7:0] din, din_n;
    logic [3:0] cnt, cnt_n;
    logic       tx_n, done_n;
    logic       u_clk;

    uart_div #(.clk_freq(clk_freq), .baud_rate(baud_rate)) udiv (
        .clk(clk),
        .rst(rst),
        .u_clk(u_clk)
    );

    // frame state and line outputs advance once per bit period
    always_ff @(posedge u_clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            din    <= 8'h00;
            cnt    <= 4'd0;
            tx     <= 1'b1;
            donetx <= 1'b0;
        end else begin
            state  <= state_n;
            din    <= din_n;
            cnt    <= cnt_n;
            tx     <= tx_n;
            donetx <= done_n;
        end
    end

    // idle line is high; the edge after the 8th data bit drives stop and done together
    always_comb begin
        state_n = state;
        din_n   = din;
        cnt_n   = cnt;
        tx_n    = 1'b1;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (newd) begin
                din_n   = dintx;
                tx_n    = 1'b0;
                cnt_n   = 4'd0;
                state_n = TRANSFER;
            end
        end else if (cnt < 4'd8) begin
            tx_n  = din[cnt[2:0]];
            cnt_n = cnt + 4'd1;
        end else begin
            done_n  = 1'b1;
            cnt_n   = 4'd0;
            state_n = IDLE;
        end
    end
endmodule

// uartrx: waits for a low sample, then collects 8 bits LSB first; stop bit is ignored
module uartrx #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] doutrx,
    output logic       donerx
);
    typedef enum logic {IDLE, START} state_t;

    state_t     state, state_n;
    logic [7:0] shreg, shreg_n, dout_n;
    logic [2:0] cnt, cnt_n;
    logic       done_n;
    logic       u_clk;

    uart_div #(.clk_freq(clk_freq), .baud_rate(baud_rate)) udiv (
        .clk(clk),
        .rst(rst),
        .u_clk(u_clk)
    );

    // receive state, shift register and the held output byte
    always_ff @(posedge u_clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= 8'h00;
            cnt    <= 3'd0;
            doutrx <= 8'h00;
            donerx <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            cnt    <= cnt_n;
            doutrx <= dout_n;
            donerx <= done_n;
        end
    end

    // new bits enter at the top so the first-received bit ends up as the LSB
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        dout_n  = doutrx;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (!rx) begin
                cnt_n   = 3'd0;
                state_n = START;
            end
        end else begin
            shreg_n = {rx, shreg[7:1]};
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
                dout_n  = shreg_n;
                done_n  = 1'b1;
                state_n = IDLE;
            end
        end
    end
endmodule

// uarttop: independent transmit and receive paths sharing only clk and rst
module uarttop #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [7:0] dintx,
    input  logic       newd,
    output logic       tx,
    output logic [7:0] doutrx,
    output logic       donetx,
    output logic       donerx
);
    uarttx #(.clk_freq(clk_freq), .baud_rate(baud_rate)) utx (
        .clk(clk),
        .rst(rst),
        .newd(newd),
        .dintx(dintx),
        .tx(tx),
        .donetx(donetx)
    );

    uartrx #(.clk_freq(clk_freq), .baud_rate(baud_rate)) urx (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .doutrx(doutrx),
        .donerx(donerx)
    );
endmodule

// File: tb/tb_uarttop.sv
// tb_uarttop: bit-level reference model of 8N1 framing checked against uarttop every bit period
module tb_uarttop;
    logic       clk = 1'b0, rst = 1'b0, rx = 1'b1, newd = 1'b0;
    logic [7:0] dintx = 8'h00;
    logic       tx, donetx, donerx;
    logic [7:0] doutrx;
    int         vectors = 0, errors = 0;

    always #5 clk = ~clk;

    uarttop dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .dintx(dintx),
        .newd(newd),
        .tx(tx),
        .doutrx(doutrx),
        .donetx(donetx),
        .donerx(donerx)
    );

    logic [1:0] txq[$];
    logic [9:0] rxq[$];
    logic       exp_tx = 1'b1, exp_dt = 1'b0, exp_dr = 1'b0;
    logic [7:0] exp_dout = 8'h00;
    logic       cur_flag = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    time        t_last = 0, t_prev = 0;
    logic [9:0] txhist = '0, dthist = '0;
    int         dt_rises = 0, dr_rises = 0;
    logic       prev_dt = 1'b0, prev_dr = 1'b0;
    bit         bw_hit;

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rx(logic [7:0] b);
        rxq.push_back({1'b0, 1'b0, 8'h00});
        for (int i = 0; i < 8; i++) rxq.push_back({b[i], i == 7, b});
        rxq.push_back({1'b1, 1'b0, 8'h00});
    endtask

    task bit_wait(int n);
        for (int k = 0; k < n; k++) begin
            bw_hit = 1'b0;
            fork
                begin @(negedge dut.utx.u_clk); bw_hit = 1'b1; end
                begin repeat (300) @(posedge clk); end
            join_any
            disable fork;
            if (!bw_hit) begin
                vectors++;
                errors++;
                $display("FAIL bit_clock_timeout: got no u_clk edge in 300 clk cycles, expected one per 104");
            end
            #2;
        end
    endtask

    // reference: a frame is queued as ten (tx, donetx) bit periods when newd is seen idle
    always @(posedge dut.utx.u_clk or posedge rst) begin
        if (rst) begin
            txq.delete();
            exp_tx = 1'b1; exp_dt = 1'b0; exp_dr = 1'b0; exp_dout = 8'h00;
            t_last = 0; t_prev = 0;
        end else begin
            t_prev = t_last;
            t_last = $time;
            if (txq.size() == 0 && newd) begin
                txq.push_back(2'b00);
                for (int i = 0; i < 8; i++) txq.push_back({dintx[i], 1'b0});
                txq.push_back(2'b11);
            end
            if (txq.size() > 0) {exp_tx, exp_dt} = txq.pop_front();
            else {exp_tx, exp_dt} = 2'b10;
            exp_dr = cur_flag;
            if (cur_flag) exp_dout = cur_byte;
        end
    end

    // serial line driver: one queued bit per period, changed mid-period
    always @(negedge dut.utx.u_clk) begin
        if (!rst) begin
            if (rxq.size() > 0) {rx, cur_flag, cur_byte} = rxq.pop_front();
            else begin rx = 1'b1; cur_flag = 1'b0; end
        end
    end

    // compare every bit period, mid-period
    always @(negedge dut.utx.u_clk) begin
        if (!rst) begin
            check("tx", int'(tx), int'(exp_tx));
            check("donetx", int'(donetx), int'(exp_dt));
            check("donerx", int'(donerx), int'(exp_dr));
            check("doutrx", int'(doutrx), int'(exp_dout));
            txhist = {txhist[8:0], tx};
            dthist = {dthist[8:0], donetx};
            if (donetx && !prev_dt) dt_rises++;
            if (donerx && !prev_dr) dr_rises++;
            prev_dt = donetx;
            prev_dr = donerx;
        end
    end

    initial begin
        logic [7:0] bytes[10];
        int r0, d0;
        #1 rst = 1'b1;
        #1;
        check("reset_tx", int'(tx), 1);
        check("reset_donetx", int'(donetx), 0);
        check("reset_donerx", int'(donerx), 0);
        check("reset_doutrx", int'(doutrx), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        bit_wait(4);
        check("u_clk_period_ns", int'(t_last - t_prev), 1040);
        newd = 1'b1;
        dintx = 8'hA5;
        bit_wait(1);
        newd = 1'b0;
        bit_wait(9);
        check("tx_a5_bits", int'(txhist), int'(10'b0101001011));
        check("donetx_a5", int'(dthist), int'(10'b0000000001));
        bit_wait(2);
        r0 = dr_rises;
        push_rx(8'h3C);
        bit_wait(13);
        check("doutrx_3c", int'(doutrx), 'h3C);
        check("donerx_3c_pulses", dr_rises - r0, 1);
        for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
        r0 = dr_rises;
        d0 = dt_rises;
        for (int i = 0; i < 10; i++) push_rx(bytes[i]);
        newd = 1'b1;
        dintx = bytes[0];
        for (int k = 0; k < 10; k++) begin
            bit_wait(2);
            dintx = (k < 9) ? bytes[k+1] : 8'h00;
            bit_wait(8);
        end
        newd = 1'b0;
        bit_wait(5);
        check("donetx_b2b_pulses", dt_rises - d0, 10);
        check("donerx_b2b_pulses", dr_rises - r0, 10);
        check("doutrx_b2b_last", int'(doutrx), int'(bytes[9]));
        d0 = dt_rises;
        newd = 1'b1;
        dintx = 8'h00;
        bit_wait(1);
        newd = 1'b0;
        bit_wait(5);
        check("tx_bit4_before_reset", int'(tx), 0);
        rst = 1'b1;
        #1;
        check("midtx_reset_tx", int'(tx), 1);
        check("midtx_reset_donetx", int'(donetx), 0);
        check("midtx_reset_donerx", int'(donerx), 0);
        check("midtx_reset_doutrx", int'(doutrx), 0);
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        bit_wait(15);
        check("donetx_after_reset", dt_rises - d0, 0);
        check("tx_idle_after_reset", int'(tx), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/uarttop.md
UARTTOP -- requirements
Module: uarttop

Interface
REQ-001 Parameter clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600, serial bit rate in baud.
REQ-003 clk  input  1  single system clock; all logic is derived from it.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  serial receive line; idle-high.
REQ-006 dintx  input  8  transmit data byte; latched at frame start.
REQ-007 newd  input  1  transmit request; level-sensitive, sampled on bit-clock edges.
REQ-008 tx  output  1  serial transmit line; idle-high.
REQ-009 doutrx  output  8  last received byte.
REQ-010 donetx  output  1  transmit-complete pulse.
REQ-011 donerx  output  1  receive-complete pulse.
REQ-012 Port order SHALL be clk, rst, rx, dintx, newd, tx, doutrx, donetx, donerx.
REQ-013 Transmitter instance SHALL be named utx and SHALL contain a bit-clock signal u_clk, so benches can reference dut.utx.u_clk hierarchically.

Function
REQ-014 Bit-clock divisor SHALL be clkcount = clk_freq / baud_rate (integer division; 104 at defaults).
- Transmitter and receiver each derive a bit clock u_clk.
- u_clk toggles every clkcount/2 clk cycles, giving a period of 104 clk cycles at defaults.
REQ-015 All transmit and receive state SHALL update only on posedge u_clk of the respective block.
REQ-016 Frame format SHALL be 8N1:
- start bit 0;
- 8 data bits, LSB first;
- stop level 1;
- no parity.
REQ-017 TX FSM SHALL have states IDLE and TRANSFER.
REQ-018 TX IDLE: tx=1, donetx=0.
- On an edge with newd=1: latch dintx, drive tx=0 (start bit), clear bit counter, go to TRANSFER.
REQ-019 TX TRANSFER: on each of the next 8 edges drive tx = latched[i], for i = 0..7.
- On the following edge drive tx=1 and donetx=1, then return to IDLE.
- donetx is therefore high for exactly one u_clk period per frame.
REQ-020 If newd remains high, the next frame SHALL start on the first IDLE edge.
- Each frame re-latches dintx.
- donetx SHALL return to 0 between frames, so each frame gives a distinct rising edge.
REQ-021 dintx changes during TRANSFER SHALL NOT affect the frame in progress.
REQ-022 RX FSM SHALL have states IDLE and START.
- IDLE: donerx=0; rx=0 sampled on an edge goes to START with bit counter 0.
REQ-023 RX START: sample rx on each of the next 8 edges, shifting right (shreg = {rx, shreg[7:1]}).
- On the 8th sample: doutrx <= completed byte, donerx=1, return to IDLE.
- donerx is therefore high for one u_clk period.
REQ-024 The stop bit SHALL NOT be checked.
- Any rx=0 sampled in RX IDLE starts a new frame, including directly after donerx.
REQ-025 doutrx SHALL hold its value until the next completed frame.
REQ-026 TX and RX SHALL operate independently and concurrently.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for a clock, force:
- tx=1, donetx=0, donerx=0, doutrx=8'h00;
- both FSMs to IDLE;
- all bit and divider counters to 0;
- u_clk=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame.
- No done pulse is generated for the aborted frame.
- After release, a new frame starts only on a new newd request or a new rx start bit.

Verification
REQ-029 Divider: at defaults with a 10 ns clk, the u_clk period SHALL measure 104 clk cycles (1040 ns).
REQ-030 TX byte: newd=1, dintx=8'hA5.
- Required tx on successive u_clk edges: 0,1,0,1,0,0,1,0,1,1.
- donetx is high for one u_clk period at the stop bit.
REQ-031 RX byte: rx=0 for one bit, then 0,0,1,1,1,1,0,0 on successive u_clk edges -> doutrx=8'h3C, donerx pulse of one u_clk period.
REQ-032 Back-to-back TX: newd held high for 10 random bytes.
- Each frame's 8 data bits equal its dintx.
- There are 10 distinct donetx rising edges.
REQ-033 Back-to-back RX: 10 random frames with no idle gap -> each doutrx equals the driven byte, with 10 donerx pulses.
REQ-034 Reset mid-TX at bit 4 -> tx=1 and donetx=0 immediately, and no donetx pulse follows.
